e_mdu_ctrl: RTL and testbench

//   Execute-stage multiply/divide unit with its own sequencer. Owns the architectural HI/LO registers.

---
 rtl/e_mdu_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_e_mdu_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/e_mdu_ctrl.sv
// ---------------------------------------------------------------------------
// e_mdu_ctrl -- execute-stage multiply/divide unit and its sequencer.
//
// This unit owns the architectural HI/LO registers. mult/multu/div/divu
// compute their result at the start edge into pending registers. The unit
// then stays busy for a fixed number of cycles. The pending result is
// committed to HI/LO on the edge where the busy counter runs out.
// mthi/mtlo write HI/LO in one cycle. mfhi/mflo read HI/LO onto the E-stage
// result mux.
//
// Ports
//   clk           in   1   rising-edge clock
//   reset         in   1   asynchronous, active-low; clears all state
//   E_MDUA        in  32   operand rs (forwarded)
//   E_MDUB        in  32   operand rt (forwarded)
//   E_MDUOp       in   4   0 none, 1 mult, 2 multu, 3 div, 4 divu,
//                          5 mfhi, 6 mflo, 7 mthi, 8 mtlo, others none
//   E_Req         in   1   flush: the E instruction must not take effect
//   E_MDUBusy     out  1   registered, high while a multi-cycle op runs
//   E_MDUStallReq out  1   start request this cycle, or busy
//   E_MDURe       out 32   HI for mfhi, LO for mflo, else 0
//   E_HI, E_LO    out 32   architectural HI/LO
// ---------------------------------------------------------------------------
module e_mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] E_MDUA,
  input  logic [31:0] E_MDUB,
  input  logic [3:0]  E_MDUOp,
  input  logic        E_Req,
  output logic        E_MDUBusy,
  output logic        E_MDUStallReq,
  output logic [31:0] E_MDURe,
  output logic [31:0] E_HI,
  output logic [31:0] E_LO
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MULT = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_DIV  = CNT_W'(DIV_CYCLES);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [31:0]        r_hi;
  logic [31:0]        r_lo;
  logic [31:0]        r_phi;
  logic [31:0]        r_plo;
  logic               r_pwr;   // pending result is to be written at commit
  logic               r_busy;

  // Two's-complement negate of a magnitude when the result must be negative.
  function automatic logic [31:0] f_apply_sign(input logic [31:0] mag, input logic neg);
    return neg ? (32'd0 - mag) : mag;
  endfunction

  // Products: both operands widened to 64 bits so the multiply is exact.
  logic signed [63:0] w_a_s64;
  logic signed [63:0] w_b_s64;
  logic signed [63:0] w_prod_s;
  logic        [63:0] w_prod_u;

  assign w_a_s64  = {{32{E_MDUA[31]}}, E_MDUA};
  assign w_b_s64  = {{32{E_MDUB[31]}}, E_MDUB};
  assign w_prod_s = w_a_s64 * w_b_s64;
  assign w_prod_u = {32'd0, E_MDUA} * {32'd0, E_MDUB};

  // Division runs on magnitudes through one unsigned divider. The signs are
  // applied afterwards. For 0x80000000 / -1 this gives quotient 0x80000000
  // and remainder 0 without any special case.
  logic        w_div_signed;
  logic        w_neg_a;
  logic        w_neg_b;
  logic [31:0] w_mag_a;
  logic [31:0] w_mag_b;
  logic [31:0] w_divisor;
  logic [31:0] w_q_mag;
  logic [31:0] w_r_mag;
  logic [31:0] w_quot;
  logic [31:0] w_rem;
  logic        w_b_zero;

  assign w_div_signed = (E_MDUOp == OP_DIV);
  assign w_neg_a      = w_div_signed & E_MDUA[31];
  assign w_neg_b      = w_div_signed & E_MDUB[31];
  assign w_mag_a      = f_apply_sign(E_MDUA, w_neg_a);
  assign w_mag_b      = f_apply_sign(E_MDUB, w_neg_b);
  assign w_b_zero     = (E_MDUB == 32'd0);
  // Keep the divider defined on a zero divisor; its result is discarded then.
  assign w_divisor    = w_b_zero ? 32'd1 : w_mag_b;
  assign w_q_mag      = w_mag_a / w_divisor;
  assign w_r_mag      = w_mag_a % w_divisor;
  assign w_quot       = f_apply_sign(w_q_mag, w_neg_a ^ w_neg_b);
  assign w_rem        = f_apply_sign(w_r_mag, w_neg_a);

  logic w_start_req;
  assign w_start_req = (E_MDUOp >= OP_MULT) && (E_MDUOp <= OP_DIVU) && !E_Req;

  // Sequencer: IDLE accepts starts and mthi/mtlo. BUSY counts down and
  // commits on the final edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
      r_phi   <= 32'd0;
      r_plo   <= 32'd0;
      r_pwr   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!E_Req) begin
            case (E_MDUOp)
              OP_MULT, OP_MULTU: begin
                {r_phi, r_plo} <= (E_MDUOp == OP_MULT) ? w_prod_s : w_prod_u;
                r_pwr   <= 1'b1;
                r_cnt   <= CNT_MULT;
                r_busy  <= 1'b1;
                r_state <= S_BUSY;
              end
              OP_DIV, OP_DIVU: begin
                r_phi   <= w_rem;
                r_plo   <= w_quot;
                r_pwr   <= !w_b_zero;
                r_cnt   <= CNT_DIV;
                r_busy  <= 1'b1;
                r_state <= S_BUSY;
              end
              OP_MTHI: r_hi <= E_MDUA;
              OP_MTLO: r_lo <= E_MDUA;
              default: ;
            endcase
          end
        end
        S_BUSY: begin
          r_cnt <= r_cnt - CNT_ONE;
          if (r_cnt == CNT_ONE) begin
            if (r_pwr) begin
              r_hi <= r_phi;
              r_lo <= r_plo;
            end
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    E_MDURe = 32'd0;
    case (E_MDUOp)
      OP_MFHI: E_MDURe = r_hi;
      OP_MFLO: E_MDURe = r_lo;
      default: E_MDURe = 32'd0;
    endcase
  end

  assign E_MDUBusy     = r_busy;
  assign E_MDUStallReq = w_start_req || r_busy;
  assign E_HI          = r_hi;
  assign E_LO          = r_lo;

endmodule

// File: tb/tb_e_mdu_ctrl.sv
// Testbench for e_mdu_ctrl: directed cases plus randomized traffic, checked
// against a cycle-level reference model of HI/LO and busy timing.
module tb_e_mdu_ctrl;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  op;
  logic        req;
  logic        busy;
  logic        stall;
  logic [31:0] re;
  logic [31:0] hi;
  logic [31:0] lo;

  e_mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .E_MDUA(a), .E_MDUB(b), .E_MDUOp(op), .E_Req(req),
    .E_MDUBusy(busy), .E_MDUStallReq(stall), .E_MDURe(re), .E_HI(hi), .E_LO(lo)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: architectural HI/LO, the result waiting to land, and
  // the edge number at which it lands.
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  logic [31:0] m_phi = 32'd0;
  logic [31:0] m_plo = 32'd0;
  logic        m_pwr = 1'b0;
  int          edges = 0;
  int          done_edge = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one instruction for one cycle, check outputs mid-cycle, then
  // advance the model across the rising edge.
  task automatic step(input logic [3:0] o, input logic [31:0] xa, input logic [31:0] xb,
                      input logic xr);
    logic [63:0] p;
    longint sa, sb, q, r;
    longint unsigned ua, ub;
    logic mbusy;
    op = o; a = xa; b = xb; req = xr;
    @(negedge clk);
    mbusy = (edges < done_edge);
    chk("busy", {31'd0, busy}, {31'd0, mbusy});
    chk("stall", {31'd0, stall}, {31'd0, (((o >= 4'd1) && (o <= 4'd4)) && !xr) || mbusy});
    chk("re", re, (o == 4'd5) ? m_hi : (o == 4'd6) ? m_lo : 32'd0);
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
    @(posedge clk);
    edges++;
    if (mbusy) begin
      if (edges == done_edge && m_pwr) begin
        m_hi = m_phi;
        m_lo = m_plo;
      end
    end else if (!xr) begin
      case (o)
        4'd1: begin
          sa = $signed(xa); sb = $signed(xb); p = sa * sb;
          m_phi = p[63:32]; m_plo = p[31:0]; m_pwr = 1'b1; done_edge = edges + MC;
        end
        4'd2: begin
          ua = xa; ub = xb; p = ua * ub;
          m_phi = p[63:32]; m_plo = p[31:0]; m_pwr = 1'b1; done_edge = edges + MC;
        end
        4'd3: begin
          m_pwr = (xb != 32'd0);
          if (m_pwr) begin
            sa = $signed(xa); sb = $signed(xb); q = sa / sb; r = sa % sb;
            p = q; m_plo = p[31:0];
            p = r; m_phi = p[31:0];
          end
          done_edge = edges + DC;
        end
        4'd4: begin
          m_pwr = (xb != 32'd0);
          if (m_pwr) begin
            m_plo = xa / xb;
            m_phi = xa % xb;
          end
          done_edge = edges + DC;
        end
        4'd7: m_hi = xa;
        4'd8: m_lo = xa;
        default: ;
      endcase
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(4'd0, $urandom, $urandom, 1'b0);
  endtask

  // Asynchronous reset asserted between edges and checked before the next edge.
  task automatic async_reset();
    #2 reset = 1'b0;
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    m_hi = 32'd0; m_lo = 32'd0; m_pwr = 1'b0; done_edge = 0;
    @(posedge clk);
    #1 reset = 1'b1;
  endtask

  function automatic logic [31:0] ropnd();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset = 1'b0; a = 32'd0; b = 32'd0; op = 4'd0; req = 1'b0;
    #1;
    chk("por_busy", {31'd0, busy}, 32'd0);
    chk("por_hi", hi, 32'd0);
    chk("por_lo", lo, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;

    idle(1);
    // mult -3 * 5
    step(4'd1, 32'hFFFF_FFFD, 32'd5, 1'b0);
    idle(MC + 1);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFF1);
    op = 4'd6; #1;
    chk("mflo", re, 32'hFFFF_FFF1);
    step(4'd6, 32'd0, 32'd0, 1'b0);

    // multu 0xFFFFFFFF * 2
    step(4'd2, 32'hFFFF_FFFF, 32'd2, 1'b0);
    idle(MC + 1);
    chk("multu_hi", hi, 32'h0000_0001);
    chk("multu_lo", lo, 32'hFFFF_FFFE);

    // div -7 / 2
    step(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
    idle(DC + 1);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);

    // divu by zero keeps HI/LO
    step(4'd7, 32'h11, 32'd0, 1'b0);
    step(4'd8, 32'h22, 32'd0, 1'b0);
    step(4'd4, 32'd7, 32'd0, 1'b0);
    idle(DC + 1);
    chk("divz_hi", hi, 32'h11);
    chk("divz_lo", lo, 32'h22);

    // flushed mult and mthi
    step(4'd1, 32'd3, 32'd3, 1'b1);
    idle(1);
    chk("flush_mult_lo", lo, 32'h22);
    step(4'd7, 32'h1234, 32'd0, 1'b1);
    idle(1);
    chk("flush_mthi", hi, 32'h11);
    step(4'd7, 32'h1234, 32'd0, 1'b0);
    chk("mthi", hi, 32'h1234);

    // signed overflow division
    step(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    idle(DC + 1);
    chk("ovf_lo", lo, 32'h8000_0000);
    chk("ovf_hi", hi, 32'd0);

    // reset in the middle of a divide, then a normal mult
    step(4'd7, 32'h55, 32'd0, 1'b0);
    step(4'd3, 32'd100, 32'd7, 1'b0);
    idle(3);
    async_reset();
    step(4'd1, 32'd2, 32'd3, 1'b0);
    idle(MC + 1);
    chk("post_rst_lo", lo, 32'd6);
    chk("post_rst_hi", hi, 32'd0);

    // randomized traffic, including ops presented while busy
    for (int i = 0; i < 600; i++) begin
      logic [3:0] ro;
      ro = 4'($urandom_range(0, 15));
      step(ro, ropnd(), ropnd(), ($urandom_range(0, 7) == 0));
    end
    idle(DC + 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
